// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//   Scans a 4x4 active-low matrix keypad one column at a time. Row samples are
//   debounced over several dwell periods. The block then reports a single
//   accepted key as a held level (key_pressed) plus a one-cycle strobe
//   (key_strobe). key_value stays stable for as long as key_pressed is high,
//   and it keeps its last value after the key is released.
//
//   State table:
//     state       | meaning
//     ------------+---------------------------------------------------------
//     ST_SCAN     | rotating column drive, waiting for exactly one low row
//     ST_DEBOUNCE | column held, counting identical row samples
//     ST_PRESSED  | key accepted, counting consecutive all-idle samples
//
// Parameters:
//   SCAN_DIV     clock cycles each column is driven (dwell), >= 4
//   DEBOUNCE_CNT identical dwell samples needed for press/release, >= 2
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   row_in[3:0]  keypad rows, active-low, asynchronous to clk
//   col_out[3:0] column drive, one-hot active-low
//   key_value    code of the accepted key
//   key_pressed  high while the accepted key is held
//   key_strobe   one-cycle pulse on acceptance
// -----------------------------------------------------------------------------
module keypad_scanner #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_value,
  output logic       key_pressed,
  output logic       key_strobe
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_TARGET = CW'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Row synchronizer (rows idle high, so reset to all ones)
  // ---------------------------------------------------------------------------
  logic [3:0] row_s1;
  logic [3:0] row_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_s1 <= 4'hF;
      row_s  <= 4'hF;
    end else begin
      row_s1 <= row_in;
      row_s  <= row_s1;
    end
  end

  // ---------------------------------------------------------------------------
  // Dwell timer: the sample point is the last count of each dwell period
  // ---------------------------------------------------------------------------
  logic [DW-1:0] dwell_cnt;
  logic          sample;

  assign sample = (dwell_cnt == DWELL_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dwell_cnt <= '0;
    end else if (sample) begin
      dwell_cnt <= '0;
    end else begin
      dwell_cnt <= dwell_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Row classification
  // ---------------------------------------------------------------------------
  logic row_idle;
  logic row_valid;

  assign row_idle = (row_s == 4'hF);

  always_comb begin
    row_valid = 1'b0;
    case (row_s)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: row_valid = 1'b1;
      default:                            row_valid = 1'b0;
    endcase
  end

  // Index of the single low bit; only meaningful for a valid row pattern.
  function automatic logic [1:0] row_index(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    case (rows)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Keypad legend; * and # map to E and F.
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    code = 4'h0;
    case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      4'b11_11: code = 4'hD;
      default:  code = 4'h0;
    endcase
    return code;
  endfunction

  // ---------------------------------------------------------------------------
  // FSM and registered outputs
  // ---------------------------------------------------------------------------
  state_t        state, state_d;
  logic [1:0]    col_idx, col_idx_d;
  logic [CW-1:0] deb_cnt, deb_cnt_d;
  logic [CW-1:0] rel_cnt, rel_cnt_d;
  logic [3:0]    row_cap, row_cap_d;
  logic [3:0]    col_out_d;
  logic [3:0]    key_value_d;
  logic          key_pressed_d;
  logic          key_strobe_d;
  logic [CW-1:0] deb_inc;
  logic [CW-1:0] rel_inc;

  assign deb_inc = deb_cnt + 1'b1;
  assign rel_inc = rel_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_SCAN;
      col_idx     <= 2'd0;
      deb_cnt     <= '0;
      rel_cnt     <= '0;
      row_cap     <= 4'hF;
      col_out     <= 4'b1110;
      key_value   <= 4'h0;
      key_pressed <= 1'b0;
      key_strobe  <= 1'b0;
    end else begin
      state       <= state_d;
      col_idx     <= col_idx_d;
      deb_cnt     <= deb_cnt_d;
      rel_cnt     <= rel_cnt_d;
      row_cap     <= row_cap_d;
      col_out     <= col_out_d;
      key_value   <= key_value_d;
      key_pressed <= key_pressed_d;
      key_strobe  <= key_strobe_d;
    end
  end

  always_comb begin
    state_d       = state;
    col_idx_d     = col_idx;
    deb_cnt_d     = deb_cnt;
    rel_cnt_d     = rel_cnt;
    row_cap_d     = row_cap;
    key_value_d   = key_value;
    key_pressed_d = key_pressed;
    key_strobe_d  = 1'b0;

    if (sample) begin
      case (state)
        ST_SCAN: begin
          if (row_valid) begin
            // Column stays put so the same key keeps being sampled.
            row_cap_d = row_s;
            deb_cnt_d = CW'(1);
            state_d   = ST_DEBOUNCE;
          end else begin
            col_idx_d = col_idx + 2'd1;
          end
        end

        ST_DEBOUNCE: begin
          if (row_s == row_cap) begin
            deb_cnt_d = deb_inc;
            if (deb_inc == CNT_TARGET) begin
              state_d       = ST_PRESSED;
              key_value_d   = key_code(row_index(row_cap), col_idx);
              key_pressed_d = 1'b1;
              key_strobe_d  = 1'b1;
              deb_cnt_d     = '0;
              rel_cnt_d     = '0;
            end
          end else begin
            state_d   = ST_SCAN;
            col_idx_d = col_idx + 2'd1;
            deb_cnt_d = '0;
          end
        end

        ST_PRESSED: begin
          // Any non-idle sample (same key, another key, or a multi-row
          // pattern) restarts the release count; key_value is untouched.
          if (row_idle) begin
            rel_cnt_d = rel_inc;
            if (rel_inc == CNT_TARGET) begin
              state_d       = ST_SCAN;
              key_pressed_d = 1'b0;
              col_idx_d     = col_idx + 2'd1;
              rel_cnt_d     = '0;
            end
          end else begin
            rel_cnt_d = '0;
          end
        end

        default: begin
          state_d   = ST_SCAN;
          col_idx_d = 2'd0;
          deb_cnt_d = '0;
          rel_cnt_d = '0;
        end
      endcase
    end

    col_out_d = ~(4'b0001 << col_idx_d);
  end

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

  logic       clk;
  logic       rst;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_value;
  logic       key_pressed;
  logic       key_strobe;

  logic [15:0] keys;   // bit r*4+c set = key at row r, column c held
  int checks;
  int failures;
  int cyc;
  int strobe_cnt;

  localparam int K1    = 0;   // r0 c0
  localparam int K3    = 2;   // r0 c2
  localparam int KA    = 3;   // r0 c3
  localparam int K4    = 4;   // r1 c0
  localparam int K5    = 5;   // r1 c1
  localparam int KHASH = 14;  // r3 c2

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .row_in      (row_in),
    .col_out     (col_out),
    .key_value   (key_value),
    .key_pressed (key_pressed),
    .key_strobe  (key_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad: a row is pulled low when a held key sits in a driven column.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (key_strobe) strobe_cnt <= strobe_cnt + 1;
  end

  task automatic tick_to(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " col_out"}, 32'(col_out), 32'h0000_000E);
    check({tag, " key_value"}, 32'(key_value), 32'h0);
    check({tag, " key_pressed"}, 32'(key_pressed), 32'h0);
    check({tag, " key_strobe"}, 32'(key_strobe), 32'h0);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    cyc        = 0;
    strobe_cnt = 0;
    rst        = 1'b0;
    keys       = '0;
    keys[K5]   = 1'b1;

    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;

    // 1: hold "5"; first column-1 sample at cycle 8, acceptance 8 cycles later
    tick_to(15);
    check("k5 pre pressed", 32'(key_pressed), 32'h0);
    check("k5 pre col", 32'(col_out), 32'hD);
    tick_to(16);
    check("k5 pressed", 32'(key_pressed), 32'h1);
    check("k5 strobe", 32'(key_strobe), 32'h1);
    check("k5 value", 32'(key_value), 32'h5);
    check("k5 col", 32'(col_out), 32'hD);
    tick_to(17);
    check("k5 strobe one cycle", 32'(key_strobe), 32'h0);
    check("k5 strobe count", 32'(strobe_cnt), 32'd1);
    tick_to(24);
    check("k5 held col", 32'(col_out), 32'hD);
    check("k5 held pressed", 32'(key_pressed), 32'h1);

    // 2: release "5"; first idle sample at 28, release at 36, column 2 next
    keys[K5] = 1'b0;
    tick_to(35);
    check("rel5 pre pressed", 32'(key_pressed), 32'h1);
    tick_to(36);
    check("rel5 pressed", 32'(key_pressed), 32'h0);
    check("rel5 col", 32'(col_out), 32'hB);
    check("rel5 value", 32'(key_value), 32'h5);

    // 3: bounce on "#": seen at 40, idle at 44 aborts, re-accepted at 68
    keys[KHASH] = 1'b1;
    tick_to(40);
    keys[KHASH] = 1'b0;
    tick_to(44);
    check("bounce abort col", 32'(col_out), 32'h7);
    check("bounce abort pressed", 32'(key_pressed), 32'h0);
    keys[KHASH] = 1'b1;
    tick_to(67);
    check("bounce no strobe", 32'(strobe_cnt), 32'd1);
    check("bounce pre pressed", 32'(key_pressed), 32'h0);
    tick_to(68);
    check("hash pressed", 32'(key_pressed), 32'h1);
    check("hash strobe", 32'(key_strobe), 32'h1);
    check("hash value", 32'(key_value), 32'hF);
    check("hash col", 32'(col_out), 32'hB);
    keys[KHASH] = 1'b0;
    tick_to(79);
    check("hash rel pre", 32'(key_pressed), 32'h1);
    tick_to(80);
    check("hash rel pressed", 32'(key_pressed), 32'h0);
    check("hash rel col", 32'(col_out), 32'h7);
    check("hash strobe count", 32'(strobe_cnt), 32'd2);

    // 4: "1" and "4" together in column 0 never accepted, rotation continues
    keys[K1] = 1'b1;
    keys[K4] = 1'b1;
    tick_to(87);
    check("inv col c0", 32'(col_out), 32'hE);
    tick_to(88);
    check("inv col c1", 32'(col_out), 32'hD);
    check("inv pressed", 32'(key_pressed), 32'h0);
    tick_to(92);
    check("inv col c2", 32'(col_out), 32'hB);
    tick_to(96);
    check("inv col c3", 32'(col_out), 32'h7);
    tick_to(100);
    check("inv col c0 again", 32'(col_out), 32'hE);
    tick_to(104);
    check("inv col c1 again", 32'(col_out), 32'hD);
    check("inv pressed again", 32'(key_pressed), 32'h0);
    check("inv strobe count", 32'(strobe_cnt), 32'd2);
    keys[K1] = 1'b0;
    keys[K4] = 1'b0;

    // 5: hold "A", add "3"; one idle sample at 144 then re-press, release at 164
    keys[KA] = 1'b1;
    tick_to(123);
    check("kA pre pressed", 32'(key_pressed), 32'h0);
    tick_to(124);
    check("kA pressed", 32'(key_pressed), 32'h1);
    check("kA strobe", 32'(key_strobe), 32'h1);
    check("kA value", 32'(key_value), 32'hA);
    keys[K3] = 1'b1;
    tick_to(140);
    check("kA+3 value", 32'(key_value), 32'hA);
    check("kA+3 strobe count", 32'(strobe_cnt), 32'd3);
    check("kA+3 col", 32'(col_out), 32'h7);
    keys[KA] = 1'b0;
    tick_to(144);
    keys[KA] = 1'b1;
    tick_to(152);
    keys[KA] = 1'b0;
    keys[K3] = 1'b0;
    tick_to(160);
    check("kA rel count restart", 32'(key_pressed), 32'h1);
    tick_to(163);
    check("kA rel pre", 32'(key_pressed), 32'h1);
    tick_to(164);
    check("kA rel pressed", 32'(key_pressed), 32'h0);
    check("kA rel value", 32'(key_value), 32'hA);
    check("kA rel col", 32'(col_out), 32'hE);

    // 6: reset in DEBOUNCE ("1" seen at sample 168), then re-accept
    keys[K1] = 1'b1;
    tick_to(170);
    #1 rst = 1'b0;
    #1;
    check_reset_outputs("rst debounce");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    tick_to(11);
    check("k1 pre pressed", 32'(key_pressed), 32'h0);
    check("k1 pre col", 32'(col_out), 32'hE);
    tick_to(12);
    check("k1 pressed", 32'(key_pressed), 32'h1);
    check("k1 strobe", 32'(key_strobe), 32'h1);
    check("k1 value", 32'(key_value), 32'h1);

    // reset in PRESSED, key still held
    tick_to(20);
    #1 rst = 1'b0;
    #1;
    check_reset_outputs("rst pressed");
    check("rst pressed strobe count", 32'(strobe_cnt), 32'd4);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    tick_to(11);
    check("k1 again pre pressed", 32'(key_pressed), 32'h0);
    tick_to(12);
    check("k1 again pressed", 32'(key_pressed), 32'h1);
    check("k1 again strobe", 32'(key_strobe), 32'h1);
    check("k1 again value", 32'(key_value), 32'h1);
    tick_to(13);
    check("k1 again strobe off", 32'(key_strobe), 32'h0);
    check("final strobe count", 32'(strobe_cnt), 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
